// File: rtl/ring_frame_rx_if.sv
// Serial ring receive bundle: ring input bit, node address and decoded packet fields.
interface ring_frame_rx_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 24
);
    logic              S_Data_in;
    logic [ADDR_W-1:0] My_Addr;
    logic              RX_Valid;
    logic [2:0]        RX_Type;
    logic [ADDR_W-1:0] RX_Dest;
    logic [ADDR_W-1:0] RX_Src;
    logic [DATA_W-1:0] RX_Data;
    logic              RX_For_Me;
    logic              RX_Error;
    logic              RX_Busy;

    modport master (
        output S_Data_in, My_Addr,
        input  RX_Valid, RX_Type, RX_Dest, RX_Src, RX_Data, RX_For_Me, RX_Error, RX_Busy
    );

    modport slave (
        input  S_Data_in, My_Addr,
        output RX_Valid, RX_Type, RX_Dest, RX_Src, RX_Data, RX_For_Me, RX_Error, RX_Busy
    );
endinterface

// File: rtl/ring_frame_rx.sv
// Token-ring serial receiver: deserializes TOKEN/ACK/NACK/DATA frames into decoded fields.
// Optional trailing even-parity bit over type+payload when RING_RX_PARITY_EN is defined.
module ring_frame_rx #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 24,
    parameter int IDLE_RESYNC = 8
) (
    input  logic            Clk_S,
    input  logic            Rst,
    ring_frame_rx_if.slave  rx
);
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max_of(max_of(DATA_W, 2 * ADDR_W), max_of(IDLE_RESYNC, 3));
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_TYPE   = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_RESYNC = 3'd5;
`ifdef RING_RX_PARITY_EN
    localparam logic [2:0] ST_PAR    = 3'd4;
    localparam logic [2:0] ST_END    = ST_PAR;
`else
    localparam logic [2:0] ST_END    = ST_IDLE;
`endif

    localparam logic [2:0] TY_TOKEN  = 3'b111;
    localparam logic [2:0] TY_ACK    = 3'b000;
    localparam logic [2:0] TY_NACK   = 3'b011;
    localparam logic [2:0] TY_DATA_C = 3'b010;
    localparam logic [2:0] TY_DATA_3 = 3'b001;

    logic [2:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          type_sr;
    logic [2*ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0]   data_sr;
`ifdef RING_RX_PARITY_EN
    logic                par_acc;
`endif

    logic                din;
    logic [2:0]          type_nx;
    logic [2*ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0]   data_nx;
    logic                last_type, last_addr, last_data;
    logic                type_bad, cur_short;
    logic [2:0]          pub_type;
    logic [2*ADDR_W-1:0] pub_addr;
    logic [DATA_W-1:0]   pub_data;
    logic                frame_end, frame_ok;

    assign din     = rx.S_Data_in;
    assign type_nx = {type_sr[1:0], din};
    assign addr_nx = {addr_sr[2*ADDR_W-2:0], din};
    assign data_nx = {data_sr[DATA_W-2:0], din};

    assign last_type = (cnt == CNT_W'(2));
    assign last_addr = (cnt == CNT_W'(2 * ADDR_W - 1));
    assign last_data = (cnt == CNT_W'(DATA_W - 1));
    assign type_bad  = type_nx[2] && (type_nx != TY_TOKEN);
    assign cur_short = (type_sr == TY_ACK) || (type_sr == TY_NACK);

    // The field being shifted on the final edge is taken from its next value,
    // so the outputs see the completed frame on that same edge.
    assign pub_type = (state == ST_TYPE) ? type_nx : type_sr;
    assign pub_addr = (state == ST_ADDR) ? addr_nx : addr_sr;
    assign pub_data = (state == ST_DATA) ? data_nx : data_sr;

`ifdef RING_RX_PARITY_EN
    assign frame_end = (state == ST_PAR);
    assign frame_ok  = ~(par_acc ^ din);
`else
    assign frame_end = ((state == ST_TYPE) && last_type && (type_nx == TY_TOKEN)) ||
                       ((state == ST_ADDR) && last_addr && cur_short) ||
                       ((state == ST_DATA) && last_data);
    assign frame_ok  = 1'b1;
`endif

    assign rx.RX_Busy = (state != ST_IDLE) && (state != ST_RESYNC);

    always_ff @(posedge Clk_S) begin
        if (Rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            type_sr      <= '0;
            addr_sr      <= '0;
            data_sr      <= '0;
`ifdef RING_RX_PARITY_EN
            par_acc      <= 1'b0;
`endif
            rx.RX_Valid  <= 1'b0;
            rx.RX_Type   <= '0;
            rx.RX_Dest   <= '0;
            rx.RX_Src    <= '0;
            rx.RX_Data   <= '0;
            rx.RX_For_Me <= 1'b0;
            rx.RX_Error  <= 1'b0;
        end else begin
            rx.RX_Valid  <= 1'b0;
            rx.RX_Error  <= 1'b0;
            rx.RX_For_Me <= 1'b0;

            if (frame_end) begin
                if (frame_ok) begin
                    rx.RX_Valid  <= 1'b1;
                    rx.RX_Type   <= pub_type;
                    rx.RX_For_Me <= (pub_type == TY_TOKEN) ||
                                    (pub_addr[2*ADDR_W-1:ADDR_W] == rx.My_Addr);
                    if (pub_type != TY_TOKEN) begin
                        rx.RX_Dest <= pub_addr[2*ADDR_W-1:ADDR_W];
                        rx.RX_Src  <= pub_addr[ADDR_W-1:0];
                    end
                    if ((pub_type == TY_DATA_C) || (pub_type == TY_DATA_3))
                        rx.RX_Data <= pub_data;
                end else begin
                    rx.RX_Error <= 1'b1;
                end
            end

`ifdef RING_RX_PARITY_EN
            if ((state == ST_TYPE) || (state == ST_ADDR) || (state == ST_DATA))
                par_acc <= par_acc ^ din;
            else
                par_acc <= 1'b0;
`endif

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (din) state <= ST_TYPE;
                end
                ST_TYPE: begin
                    type_sr <= type_nx;
                    if (last_type) begin
                        cnt <= '0;
                        if (type_bad) begin
                            rx.RX_Error <= 1'b1;
                            state       <= ST_RESYNC;
                        end else if (type_nx == TY_TOKEN) begin
                            state <= ST_END;
                        end else begin
                            state <= ST_ADDR;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ADDR: begin
                    addr_sr <= addr_nx;
                    if (last_addr) begin
                        cnt   <= '0;
                        state <= cur_short ? ST_END : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    data_sr <= data_nx;
                    if (last_data) begin
                        cnt   <= '0;
                        state <= ST_END;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESYNC: begin
                    if (din) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(IDLE_RESYNC - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ring_frame_rx.sv
// Directed bench for ring_frame_rx: a per-edge expectation schedule built from frame rules.
// Define RING_RX_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_ring_frame_rx;
    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 24;
    localparam int IDLE_RESYNC = 8;
    localparam int NE          = 4096;
`ifdef RING_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ring_frame_rx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ring_frame_rx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDLE_RESYNC(IDLE_RESYNC)) dut (
        .Clk_S (clk),
        .Rst   (rst),
        .rx    (bus.slave)
    );

    // Expected outcome of each clock edge, indexed by edge number (first edge = 1).
    bit          ev_valid [NE];
    bit          ev_err   [NE];
    bit          ev_busy  [NE];
    bit          ev_rst   [NE];
    bit          ev_forme [NE];
    logic [2:0]  ev_type  [NE];
    logic [3:0]  ev_dest  [NE];
    logic [3:0]  ev_src   [NE];
    logic [23:0] ev_data  [NE];

    logic [2:0]  m_type;
    logic [3:0]  m_dest, m_src;
    logic [23:0] m_data;

    int edge_n = 0;
    int vecs   = 0;
    int miss   = 0;
    int ce;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s edge %0d: got 0x%0h want 0x%0h", nm, edge_n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        #1;
        ce = edge_n;
        if (ce < NE) begin
            if (ev_rst[ce]) begin
                m_type = '0; m_dest = '0; m_src = '0; m_data = '0;
            end else if (ev_valid[ce]) begin
                m_type = ev_type[ce];
                if (ev_type[ce] != 3'b111) begin
                    m_dest = ev_dest[ce];
                    m_src  = ev_src[ce];
                end
                if (ev_type[ce] == 3'b001 || ev_type[ce] == 3'b010) m_data = ev_data[ce];
            end
            chk("valid", 32'(bus.RX_Valid),  32'(ev_valid[ce]));
            chk("error", 32'(bus.RX_Error),  32'(ev_err[ce]));
            chk("busy",  32'(bus.RX_Busy),   32'(ev_busy[ce]));
            chk("forme", 32'(bus.RX_For_Me), 32'(ev_valid[ce] & ev_forme[ce]));
            chk("type",  32'(bus.RX_Type),   32'(m_type));
            chk("dest",  32'(bus.RX_Dest),   32'(m_dest));
            chk("src",   32'(bus.RX_Src),    32'(m_src));
            chk("data",  32'(bus.RX_Data),   32'(m_data));
        end
    end

    task automatic put(input bit b, input bit busy, output int e);
        @(negedge clk);
        rst           = 1'b0;
        bus.S_Data_in = b;
        e             = edge_n + 1;
        ev_busy[e]    = busy;
    endtask

    task automatic idle(input int n);
        int e;
        repeat (n) put(1'b0, 1'b0, e);
    endtask

    task automatic do_reset(input bit b);
        @(negedge clk);
        rst                = 1'b1;
        bus.S_Data_in      = b;
        ev_rst[edge_n + 1] = 1'b1;
    endtask

    // Sends one frame; abort_at >= 0 asserts reset on that bit index instead.
    task automatic send_frame(input bit [2:0] ty, input bit [3:0] d, input bit [3:0] s,
                              input bit [23:0] dat, input bit bad_par, input int abort_at);
        bit q[$];
        bit illegal, p;
        int e;
        illegal = (ty == 3'b100) || (ty == 3'b101) || (ty == 3'b110);
        q.push_back(1'b1);
        for (int i = 2; i >= 0; i--) q.push_back(ty[i]);
        if (!illegal && ty != 3'b111) begin
            for (int i = 3; i >= 0; i--) q.push_back(d[i]);
            for (int i = 3; i >= 0; i--) q.push_back(s[i]);
            if (ty == 3'b001 || ty == 3'b010)
                for (int i = 23; i >= 0; i--) q.push_back(dat[i]);
        end
        if (!illegal && PAR_EN) begin
            p = 1'b0;
            for (int i = 1; i < q.size(); i++) p ^= q[i];
            q.push_back(p ^ bad_par);
        end
        e = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (i == abort_at) begin
                do_reset(q[i]);
                return;
            end
            put(q[i], i != q.size() - 1, e);
        end
        if (illegal || (PAR_EN && bad_par)) begin
            ev_err[e] = 1'b1;
        end else begin
            ev_valid[e] = 1'b1;
            ev_type[e]  = ty;
            ev_dest[e]  = d;
            ev_src[e]   = s;
            ev_data[e]  = dat;
            ev_forme[e] = (ty == 3'b111) || (d == bus.My_Addr);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int e;
        bus.S_Data_in = 1'b0;
        bus.My_Addr   = 4'd8;
        ev_rst[1]     = 1'b1;
        do_reset(1'b0);
        idle(2);

        // 1: TOKEN
        send_frame(3'b111, 4'd0, 4'd0, 24'd0, 1'b0, -1);
        settle();
        chk("t1_valid", 32'(bus.RX_Valid),  32'd1);
        chk("t1_type",  32'(bus.RX_Type),   32'd7);
        chk("t1_forme", 32'(bus.RX_For_Me), 32'd1);
        chk("t1_busy",  32'(bus.RX_Busy),   32'd0);

        // 2 and 3: DATA_3 to me, then ACK back-to-back
        send_frame(3'b001, 4'd8, 4'd0, 24'd1234, 1'b0, -1);
        settle();
        chk("t2_type",  32'(bus.RX_Type),   32'd1);
        chk("t2_dest",  32'(bus.RX_Dest),   32'd8);
        chk("t2_src",   32'(bus.RX_Src),    32'd0);
        chk("t2_data",  32'(bus.RX_Data),   32'h0004D2);
        chk("t2_forme", 32'(bus.RX_For_Me), 32'd1);
        send_frame(3'b000, 4'd1, 4'd8, 24'd0, 1'b0, -1);
        settle();
        chk("t3_type",  32'(bus.RX_Type),   32'd0);
        chk("t3_dest",  32'(bus.RX_Dest),   32'd1);
        chk("t3_src",   32'(bus.RX_Src),    32'd8);
        chk("t3_forme", 32'(bus.RX_For_Me), 32'd0);
        chk("t3_data",  32'(bus.RX_Data),   32'h0004D2);

        // More patterns: NACK to me, boundary DATA_C, back-to-back tokens
        send_frame(3'b011, 4'd8, 4'd3, 24'd0, 1'b0, -1);
        send_frame(3'b010, 4'd15, 4'd15, 24'hFFFFFF, 1'b0, -1);
        send_frame(3'b111, 4'd0, 4'd0, 24'd0, 1'b0, -1);
        send_frame(3'b111, 4'd0, 4'd0, 24'd0, 1'b0, -1);
        send_frame(3'b010, 4'd0, 4'd5, 24'h800001, 1'b0, -1);
        idle(3);

        // 4: illegal type, resync behaviour
        send_frame(3'b100, 4'd0, 4'd0, 24'd0, 1'b0, -1);
        settle();
        chk("t4_err",   32'(bus.RX_Error), 32'd1);
        chk("t4_valid", 32'(bus.RX_Valid), 32'd0);
        idle(3);
        put(1'b1, 1'b0, e);
        idle(IDLE_RESYNC);
        send_frame(3'b111, 4'd0, 4'd0, 24'd0, 1'b0, -1);
        settle();
        chk("t4_tok",   32'(bus.RX_Valid), 32'd1);
        send_frame(3'b101, 4'd0, 4'd0, 24'd0, 1'b0, -1);
        idle(IDLE_RESYNC - 1);
        put(1'b1, 1'b0, e);
        idle(IDLE_RESYNC);
        send_frame(3'b110, 4'd0, 4'd0, 24'd0, 1'b0, -1);
        idle(IDLE_RESYNC);
        send_frame(3'b000, 4'd8, 4'd6, 24'd0, 1'b0, -1);

        // 5: reset at bit 20 of a DATA_C frame, then an immediate ACK
        send_frame(3'b010, 4'd3, 4'd9, 24'hABCDEF, 1'b0, 20);
        settle();
        chk("t5_type",  32'(bus.RX_Type), 32'd0);
        chk("t5_dest",  32'(bus.RX_Dest), 32'd0);
        chk("t5_data",  32'(bus.RX_Data), 32'd0);
        chk("t5_busy",  32'(bus.RX_Busy), 32'd0);
        send_frame(3'b000, 4'd8, 4'd2, 24'd0, 1'b0, -1);
        settle();
        chk("t5_ack",   32'(bus.RX_Src),  32'd2);

`ifdef RING_RX_PARITY_EN
        // 6: parity
        send_frame(3'b111, 4'd0, 4'd0, 24'd0, 1'b1, -1);
        settle();
        chk("t6_err",   32'(bus.RX_Error), 32'd1);
        chk("t6_valid", 32'(bus.RX_Valid), 32'd0);
        send_frame(3'b001, 4'd8, 4'd1, 24'h123456, 1'b1, -1);
        send_frame(3'b111, 4'd0, 4'd0, 24'd0, 1'b0, -1);
        settle();
        chk("t6_ok",    32'(bus.RX_Valid), 32'd1);
        send_frame(3'b010, 4'd8, 4'd1, 24'h0F0F0F, 1'b0, -1);
`endif
        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
